// File: rtl/decimate_mc.sv
// Multi-lane decimator: keeps sample P of every M (PICK) or sums each M-sample frame (SUM).
// One-cycle latency from the completing valid_in; no backpressure, every valid sample is consumed.
module decimate_mc #(
    parameter int  NUM_CH     = 2,
    parameter int  WIDTH      = 16,
    parameter int  MAX_FACTOR = 16,
    localparam int CW         = $clog2(MAX_FACTOR) + 1,
    localparam int OW         = WIDTH + $clog2(MAX_FACTOR)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_in,
    input  logic [NUM_CH*WIDTH-1:0] data_in,
    input  logic [CW-1:0]          factor,
    input  logic [CW-1:0]          phase,
    input  logic                   mode,
    input  logic                   flush,
    output logic                   valid_out,
    output logic [NUM_CH*OW-1:0]   data_out,
    output logic                   frame_active
);
    localparam logic [CW-1:0] MAXF = CW'(MAX_FACTOR);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0]        cnt_q, cnt_d, m_q, p_q;
    logic                 mode_q;
    logic signed [OW-1:0] acc_q  [NUM_CH];
    logic signed [OW-1:0] hold_q [NUM_CH];
    logic                 valid_out_q;
    logic [NUM_CH*OW-1:0] data_out_q;

    logic                 start, last, mode_eff;
    logic [CW-1:0]        fac_c, ph_c, m_eff, p_eff, idx;
    logic signed [OW-1:0] smp_c  [NUM_CH];
    logic signed [OW-1:0] sum_c  [NUM_CH];
    logic signed [OW-1:0] pick_c [NUM_CH];

    // A frame starts on cnt==0 or on flush; the first sample uses the live controls, not the latched ones.
    always_comb begin
        start = flush || (cnt_q == '0);
        fac_c = factor;
        if (factor == '0)
            fac_c = ONE;
        else if (factor > MAXF)
            fac_c = MAXF;
        ph_c     = (phase > fac_c - ONE) ? fac_c - ONE : phase;
        m_eff    = start ? fac_c : m_q;
        p_eff    = start ? ph_c  : p_q;
        mode_eff = start ? mode  : mode_q;
        idx      = start ? '0    : cnt_q;
        last     = (idx == m_eff - ONE);
        cnt_d    = cnt_q;
        if (valid_in)
            cnt_d = last ? '0 : idx + ONE;
        else if (flush)
            cnt_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            smp_c[k]  = {{(OW-WIDTH){data_in[k*WIDTH+WIDTH-1]}}, data_in[k*WIDTH +: WIDTH]};
            sum_c[k]  = (start ? '0 : acc_q[k]) + smp_c[k];
            pick_c[k] = (p_eff == m_eff - ONE) ? smp_c[k] : hold_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            m_q         <= ONE;
            p_q         <= '0;
            mode_q      <= 1'b0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                acc_q[k]  <= '0;
                hold_q[k] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            valid_out_q <= valid_in && last;
            if (valid_in && start) begin
                m_q    <= fac_c;
                p_q    <= ph_c;
                mode_q <= mode;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (valid_in) begin
                    acc_q[k] <= (mode_eff && !last) ? sum_c[k] : '0;
                    if (!mode_eff && idx == p_eff)
                        hold_q[k] <= smp_c[k];
                    else if (flush)
                        hold_q[k] <= '0;
                    if (last)
                        data_out_q[k*OW +: OW] <= mode_eff ? sum_c[k] : pick_c[k];
                end else if (flush) begin
                    acc_q[k]  <= '0;
                    hold_q[k] <= '0;
                end
            end
        end
    end

    assign valid_out    = valid_out_q;
    assign data_out     = data_out_q;
    assign frame_active = (cnt_q != '0);
endmodule

// File: tb/tb_decimate_mc.sv
// Bench for decimate_mc: queue-based frame model checked every cycle, plus literal pulse expectations.
module tb_decimate_mc;
    localparam int NUM_CH = 2, WIDTH = 16, MAX_FACTOR = 16, CW = 5, OW = 20;

    logic                    clk = 1'b0, rst_n = 1'b0, valid_in = 1'b0, mode = 1'b0, flush = 1'b0;
    logic [NUM_CH*WIDTH-1:0] data_in = '0;
    logic [CW-1:0]           factor = 5'd4, phase = '0;
    logic                    valid_out, frame_active;
    logic [NUM_CH*OW-1:0]    data_out;

    decimate_mc #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .MAX_FACTOR(MAX_FACTOR)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
        .factor(factor), .phase(phase), .mode(mode), .flush(flush),
        .valid_out(valid_out), .data_out(data_out), .frame_active(frame_active)
    );

    always #5 clk = ~clk;

    int checks = 0, passes = 0;
    longint log0[$], log1[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic longint dout_lane(input int k);
        logic signed [OW-1:0] t;
        t = data_out[k*OW +: OW];
        return longint'(t);
    endfunction

    function automatic longint din_lane(input int k);
        logic signed [WIDTH-1:0] t;
        t = data_in[k*WIDTH +: WIDTH];
        return longint'(t);
    endfunction

    // Model: collect a frame's samples, then pick or sum once M of them have arrived.
    longint q0[$], q1[$];
    int     m_m = 1, m_p = 0;
    bit     m_mode = 1'b0, exp_vld = 1'b0;
    longint exp_d0 = 0, exp_d1 = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0.delete(); q1.delete();
            m_m = 1; m_p = 0; m_mode = 1'b0;
            exp_vld = 1'b0; exp_d0 = 0; exp_d1 = 0;
        end else begin
            exp_vld = 1'b0;
            if (flush) begin q0.delete(); q1.delete(); end
            if (valid_in) begin
                if (q0.size() == 0) begin
                    m_m    = (factor == 0) ? 1 : ((int'(factor) > MAX_FACTOR) ? MAX_FACTOR : int'(factor));
                    m_p    = (int'(phase) > m_m - 1) ? m_m - 1 : int'(phase);
                    m_mode = mode;
                end
                q0.push_back(din_lane(0));
                q1.push_back(din_lane(1));
                if (q0.size() == m_m) begin
                    exp_vld = 1'b1;
                    if (m_mode) begin
                        exp_d0 = 0; exp_d1 = 0;
                        foreach (q0[i]) begin exp_d0 += q0[i]; exp_d1 += q1[i]; end
                    end else begin
                        exp_d0 = q0[m_p]; exp_d1 = q1[m_p];
                    end
                    q0.delete(); q1.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("valid_out", longint'(valid_out), longint'(exp_vld));
        chk("data_out_lane0", dout_lane(0), exp_d0);
        chk("data_out_lane1", dout_lane(1), exp_d1);
        chk("frame_active", longint'(frame_active), longint'(q0.size() != 0));
        if (valid_out) begin
            log0.push_back(dout_lane(0));
            log1.push_back(dout_lane(1));
        end
    end

    task automatic smp(input int d0, input int d1, input bit fl = 1'b0);
        @(negedge clk);
        valid_in = 1'b1; flush = fl;
        data_in  = {16'(d1), 16'(d0)};
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0; flush = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic flush_cyc();
        @(negedge clk);
        valid_in = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic cfg(input int f, input int p, input bit m);
        factor = 5'(f); phase = 5'(p); mode = m;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("reset_valid_out", longint'(valid_out), 0);
        chk("reset_data_out", longint'(data_out), 0);
        chk("reset_frame_active", longint'(frame_active), 0);
        @(negedge clk); rst_n = 1'b1;

        // PICK M=4 P=0 with an idle gap mid-frame
        log0.delete(); log1.delete();
        cfg(4, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            smp(i, 10 * i);
            if (i == 5) idle(2);
        end
        idle(2);
        chk("pick_count", log0.size(), 3);
        chk("pick_0", log0[0], 1);
        chk("pick_1", log0[1], 5);
        chk("pick_2", log0[2], 9);
        chk("pick_lane1_2", log1[2], 90);

        // PICK M=4 P=2 uses the hold register; P=9 with M=3 clamps to the last sample
        log0.delete(); log1.delete();
        cfg(4, 2, 0);
        for (int i = 1; i <= 4; i++) smp(i, -i);
        cfg(3, 9, 0);
        for (int i = 1; i <= 3; i++) smp(i + 4, -i - 4);
        idle(2);
        chk("pick_p2", log0[0], 3);
        chk("pick_clamp", log1[1], -7);

        // SUM M=4
        log0.delete(); log1.delete();
        cfg(4, 0, 1);
        for (int i = 1; i <= 4; i++) smp(i, -i);
        idle(2);
        chk("sum_lane0", log0[0], 10);
        chk("sum_lane1", log1[0], -10);

        // SUM M=16 at the most negative sample: must not wrap
        log0.delete(); log1.delete();
        cfg(16, 0, 1);
        for (int i = 0; i < 16; i++) smp(-32768, -32768);
        idle(2);
        chk("sum_min", log0[0], -524288);

        // factor 4 -> 2 after the second sample: current frame still 4 long
        log0.delete(); log1.delete();
        cfg(4, 0, 1);
        smp(1, 0); smp(2, 0);
        cfg(2, 0, 1);
        for (int i = 3; i <= 8; i++) smp(i, 0);
        idle(2);
        chk("fchg_count", log0.size(), 3);
        chk("fchg_0", log0[0], 10);
        chk("fchg_1", log0[1], 11);
        chk("fchg_2", log0[2], 15);

        // flush alone, then flush coinciding with a valid sample
        log0.delete(); log1.delete();
        cfg(4, 0, 1);
        smp(1, 1); smp(2, 2); smp(3, 3);
        flush_cyc();
        smp(10, 1); smp(20, 1); smp(30, 1); smp(40, 1);
        smp(1, 0); smp(2, 0); smp(5, 0, 1'b1); smp(6, 0); smp(7, 0); smp(8, 0);
        idle(2);
        chk("flush_count", log0.size(), 2);
        chk("flush_0", log0[0], 100);
        chk("flush_1", log0[1], 26);

        // factor 0 -> passthrough, then factor 20 -> clamps to 16
        log0.delete(); log1.delete();
        cfg(0, 0, 0);
        smp(7, -7); smp(8, -8); smp(9, -9);
        cfg(20, 0, 1);
        for (int i = 1; i <= 16; i++) smp(i, -i);
        idle(2);
        chk("f0_count", log0.size(), 4);
        chk("f0_1", log0[1], 8);
        chk("f20_sum", log0[3], 136);
        chk("f20_sum_l1", log1[3], -136);

        // async reset mid-frame in SUM mode
        log0.delete(); log1.delete();
        cfg(4, 0, 1);
        smp(100, 1); smp(200, 2);
        @(negedge clk);
        valid_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_data_out", longint'(data_out), 0);
        chk("midrst_frame_active", longint'(frame_active), 0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) smp(i, 2 * i);
        idle(2);
        chk("midrst_count", log0.size(), 1);
        chk("midrst_sum", log0[0], 10);
        chk("midrst_sum_l1", log1[0], 20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
